// File: rtl/id_ex_stage_if.sv
// Bundle between the IF/ID register, register file and the ID/EX pipeline register.
// The stage itself binds to the slave modport; the surrounding core binds to master.
interface id_ex_stage_if;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus4;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        flush;

   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        stall;

   logic        ex_valid;
   logic        ex_illegal;
   logic [31:0] ex_rs;
   logic [31:0] ex_rt;
   logic [31:0] ex_imm;
   logic [31:0] ex_pc;
   logic [31:0] ex_jump_target;
   logic [4:0]  ex_shamt;
   logic [4:0]  ex_rt_addr;
   logic [4:0]  ex_rd_addr;
   logic [3:0]  ex_alu_control;
   logic        ex_alu_source;
   logic        ex_alu_source_shift;
   logic        ex_reg_dst;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_mem_to_reg;
   logic        ex_branch;
   logic        ex_branch_ne;
   logic        ex_jump;

   modport master (
      output id_valid, id_instr, id_pc_plus4, rs_data, rt_data, flush,
      input  rs_addr, rt_addr, stall,
      input  ex_valid, ex_illegal, ex_rs, ex_rt, ex_imm, ex_pc, ex_jump_target,
      input  ex_shamt, ex_rt_addr, ex_rd_addr, ex_alu_control,
      input  ex_alu_source, ex_alu_source_shift, ex_reg_dst, ex_reg_write,
      input  ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_branch_ne, ex_jump
   );

   modport slave (
      input  id_valid, id_instr, id_pc_plus4, rs_data, rt_data, flush,
      output rs_addr, rt_addr, stall,
      output ex_valid, ex_illegal, ex_rs, ex_rt, ex_imm, ex_pc, ex_jump_target,
      output ex_shamt, ex_rt_addr, ex_rd_addr, ex_alu_control,
      output ex_alu_source, ex_alu_source_shift, ex_reg_dst, ex_reg_write,
      output ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_branch_ne, ex_jump
   );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS instruction decode plus ID/EX pipeline register, with load-use stall detection.
// Flush, load-use hazard and an empty IF/ID each write a bubble (all-zero ID/EX).
module id_ex_stage (
   input  logic         clk,
   input  logic         reset,
   id_ex_stage_if.slave bus
);

   typedef enum logic [3:0] {
      ALU_NOP = 4'b0000,
      ALU_ADD = 4'b0001,
      ALU_SUB = 4'b0010,
      ALU_AND = 4'b0011,
      ALU_OR  = 4'b0100,
      ALU_XOR = 4'b0101,
      ALU_NOR = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_SLL = 4'b1000,
      ALU_SRL = 4'b1001,
      ALU_SRA = 4'b1010
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   typedef struct packed {
      logic        valid;
      logic        illegal;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] jump_target;
      logic [4:0]  shamt;
      logic [4:0]  rt_addr;
      logic [4:0]  rd_addr;
      logic [3:0]  alu_control;
      logic        alu_source;
      logic        alu_source_shift;
      logic        reg_dst;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic        branch_ne;
      logic        jump;
   } ex_t;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs_field;
   logic [4:0]  rt_field;
   logic [4:0]  rd_field;
   logic [15:0] imm16;

   alu_op_t dec_alu;
   logic    dec_alu_source;
   logic    dec_shift;
   logic    dec_reg_dst;
   logic    dec_reg_write_raw;
   logic    dec_mem_read;
   logic    dec_mem_write;
   logic    dec_mem_to_reg;
   logic    dec_branch;
   logic    dec_branch_ne;
   logic    dec_jump;
   logic    dec_zero_ext;
   logic    dec_illegal;
   logic    rs_used;
   logic    rt_used;

   logic    dec_reg_write;
   logic    hz;
   logic    bubble;

   ex_t     ex_d;
   ex_t     ex_q;

   assign opcode   = bus.id_instr[31:26];
   assign funct    = bus.id_instr[5:0];
   assign rs_field = bus.id_instr[25:21];
   assign rt_field = bus.id_instr[20:16];
   assign rd_field = bus.id_instr[15:11];
   assign imm16    = bus.id_instr[15:0];

   assign bus.rs_addr = rs_field;
   assign bus.rt_addr = rt_field;

   // Unsupported encodings leave every control at its zero default and only raise dec_illegal.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      dec_alu           = ALU_NOP;
      dec_alu_source    = 1'b0;
      dec_shift         = 1'b0;
      dec_reg_dst       = 1'b0;
      dec_reg_write_raw = 1'b0;
      dec_mem_read      = 1'b0;
      dec_mem_write     = 1'b0;
      dec_mem_to_reg    = 1'b0;
      dec_branch        = 1'b0;
      dec_branch_ne     = 1'b0;
      dec_jump          = 1'b0;
      dec_zero_ext      = 1'b0;
      dec_illegal       = 1'b0;
      rs_used           = 1'b0;
      rt_used           = 1'b0;

      case (opcode)
         OP_RTYPE: begin
            dec_reg_dst       = 1'b1;
            dec_reg_write_raw = 1'b1;
            rs_used           = 1'b1;
            rt_used           = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: dec_alu = ALU_ADD;
               FN_SUB, FN_SUBU: dec_alu = ALU_SUB;
               FN_AND:          dec_alu = ALU_AND;
               FN_OR:           dec_alu = ALU_OR;
               FN_XOR:          dec_alu = ALU_XOR;
               FN_NOR:          dec_alu = ALU_NOR;
               FN_SLT:          dec_alu = ALU_SLT;
               FN_SLL: begin dec_alu = ALU_SLL; dec_shift = 1'b1; rs_used = 1'b0; end
               FN_SRL: begin dec_alu = ALU_SRL; dec_shift = 1'b1; rs_used = 1'b0; end
               FN_SRA: begin dec_alu = ALU_SRA; dec_shift = 1'b1; rs_used = 1'b0; end
               FN_SLLV:         dec_alu = ALU_SLL;
               FN_SRLV:         dec_alu = ALU_SRL;
               FN_SRAV:         dec_alu = ALU_SRA;
               default: begin
                  dec_illegal       = 1'b1;
                  dec_reg_dst       = 1'b0;
                  dec_reg_write_raw = 1'b0;
                  rs_used           = 1'b0;
                  rt_used           = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
            dec_alu_source    = 1'b1;
            dec_reg_write_raw = 1'b1;
            rs_used           = 1'b1;
            case (opcode)
               OP_SLTI: dec_alu = ALU_SLT;
               OP_ANDI: begin dec_alu = ALU_AND; dec_zero_ext = 1'b1; end
               OP_ORI:  begin dec_alu = ALU_OR;  dec_zero_ext = 1'b1; end
               OP_XORI: begin dec_alu = ALU_XOR; dec_zero_ext = 1'b1; end
               default: dec_alu = ALU_ADD;
            endcase
         end
         OP_LW: begin
            dec_alu           = ALU_ADD;
            dec_alu_source    = 1'b1;
            dec_mem_read      = 1'b1;
            dec_mem_to_reg    = 1'b1;
            dec_reg_write_raw = 1'b1;
            rs_used           = 1'b1;
         end
         OP_SW: begin
            dec_alu        = ALU_ADD;
            dec_alu_source = 1'b1;
            dec_mem_write  = 1'b1;
            rs_used        = 1'b1;
            rt_used        = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec_alu       = ALU_SUB;
            dec_branch    = 1'b1;
            dec_branch_ne = (opcode == OP_BNE);
            rs_used       = 1'b1;
            rt_used       = 1'b1;
         end
         OP_J: begin
            dec_jump = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   // Writes to $zero are dropped here so the all-zero word decodes to a no-op sll.
   assign dec_reg_write = dec_reg_write_raw &
                          ((dec_reg_dst ? rd_field : rt_field) != 5'd0);

   assign hz = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rt_addr != 5'd0) &
               ((rs_used & (rs_field == ex_q.rt_addr)) |
                (rt_used & (rt_field == ex_q.rt_addr)));

   // A flush already discards this decode, so there is nothing to hold the front end for.
   assign bus.stall = hz & ~bus.flush;
   assign bubble    = bus.flush | hz | ~bus.id_valid;

   always_comb begin
      ex_d                  = '0;
      ex_d.valid            = 1'b1;
      ex_d.illegal          = dec_illegal;
      ex_d.rs               = bus.rs_data;
      ex_d.rt               = bus.rt_data;
      ex_d.imm              = dec_zero_ext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
      ex_d.pc               = bus.id_pc_plus4;
      ex_d.jump_target      = {bus.id_pc_plus4[31:28], bus.id_instr[25:0], 2'b00};
      ex_d.shamt            = bus.id_instr[10:6];
      ex_d.rt_addr          = rt_field;
      ex_d.rd_addr          = rd_field;
      ex_d.alu_control      = dec_alu;
      ex_d.alu_source       = dec_alu_source;
      ex_d.alu_source_shift = dec_shift;
      ex_d.reg_dst          = dec_reg_dst;
      ex_d.reg_write        = dec_reg_write;
      ex_d.mem_read         = dec_mem_read;
      ex_d.mem_write        = dec_mem_write;
      ex_d.mem_to_reg       = dec_mem_to_reg;
      ex_d.branch           = dec_branch;
      ex_d.branch_ne        = dec_branch_ne;
      ex_d.jump             = dec_jump;
   end

   // NOTE: pipeline state uses non-blocking assignments and every field is reset, since
   // downstream stages act on ex_* as soon as reset drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q <= '0;
      end else if (bubble) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.ex_valid            = ex_q.valid;
   assign bus.ex_illegal          = ex_q.illegal;
   assign bus.ex_rs               = ex_q.rs;
   assign bus.ex_rt               = ex_q.rt;
   assign bus.ex_imm              = ex_q.imm;
   assign bus.ex_pc               = ex_q.pc;
   assign bus.ex_jump_target      = ex_q.jump_target;
   assign bus.ex_shamt            = ex_q.shamt;
   assign bus.ex_rt_addr          = ex_q.rt_addr;
   assign bus.ex_rd_addr          = ex_q.rd_addr;
   assign bus.ex_alu_control      = ex_q.alu_control;
   assign bus.ex_alu_source       = ex_q.alu_source;
   assign bus.ex_alu_source_shift = ex_q.alu_source_shift;
   assign bus.ex_reg_dst          = ex_q.reg_dst;
   assign bus.ex_reg_write        = ex_q.reg_write;
   assign bus.ex_mem_read         = ex_q.mem_read;
   assign bus.ex_mem_write        = ex_q.mem_write;
   assign bus.ex_mem_to_reg       = ex_q.mem_to_reg;
   assign bus.ex_branch           = ex_q.branch;
   assign bus.ex_branch_ne        = ex_q.branch_ne;
   assign bus.ex_jump             = ex_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference decoder pushes the expected ID/EX contents
// when an instruction is driven; the entry is popped and compared after the clock edge.
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic reset;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic        illegal;
      logic [3:0]  alu;
      logic [9:0]  ctl;   // alu_source, shift, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch, branch_ne, jump
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] jt;
      logic [4:0]  shamt;
      logic [4:0]  rta;
      logic [4:0]  rda;
   } exp_t;

   exp_t sb_q[$];
   exp_t ex_model;   // what ID/EX holds after the last compared edge
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                       input logic [31:0] rsd, input logic [31:0] rtd,
                                       output logic rsu, output logic rtu);
      exp_t       e;
      logic [5:0] op;
      logic [5:0] fn;
      logic       legal, zx, src, sh, rdst, wr, mr, mw, m2r, br, bne, jmp;
      logic [3:0] alu;
      logic [4:0] dest;
      op = instr[31:26]; fn = instr[5:0];
      legal = 1'b1; zx = 1'b0; src = 1'b0; sh = 1'b0; rdst = 1'b0; wr = 1'b0;
      mr = 1'b0; mw = 1'b0; m2r = 1'b0; br = 1'b0; bne = 1'b0; jmp = 1'b0;
      alu = 4'h0; rsu = 1'b0; rtu = 1'b0;
      case (op)
         6'h00: begin
            rdst = 1'b1; wr = 1'b1; rsu = 1'b1; rtu = 1'b1;
            case (fn)
               6'h20, 6'h21: alu = 4'h1;
               6'h22, 6'h23: alu = 4'h2;
               6'h24: alu = 4'h3;
               6'h25: alu = 4'h4;
               6'h26: alu = 4'h5;
               6'h27: alu = 4'h6;
               6'h2A: alu = 4'h7;
               6'h00: begin alu = 4'h8; sh = 1'b1; rsu = 1'b0; end
               6'h02: begin alu = 4'h9; sh = 1'b1; rsu = 1'b0; end
               6'h03: begin alu = 4'hA; sh = 1'b1; rsu = 1'b0; end
               6'h04: alu = 4'h8;
               6'h06: alu = 4'h9;
               6'h07: alu = 4'hA;
               default: legal = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin alu = 4'h1; src = 1'b1; wr = 1'b1; rsu = 1'b1; end
         6'h0A: begin alu = 4'h7; src = 1'b1; wr = 1'b1; rsu = 1'b1; end
         6'h0C: begin alu = 4'h3; src = 1'b1; wr = 1'b1; rsu = 1'b1; zx = 1'b1; end
         6'h0D: begin alu = 4'h4; src = 1'b1; wr = 1'b1; rsu = 1'b1; zx = 1'b1; end
         6'h0E: begin alu = 4'h5; src = 1'b1; wr = 1'b1; rsu = 1'b1; zx = 1'b1; end
         6'h23: begin alu = 4'h1; src = 1'b1; wr = 1'b1; mr = 1'b1; m2r = 1'b1; rsu = 1'b1; end
         6'h2B: begin alu = 4'h1; src = 1'b1; mw = 1'b1; rsu = 1'b1; rtu = 1'b1; end
         6'h04: begin alu = 4'h2; br = 1'b1; rsu = 1'b1; rtu = 1'b1; end
         6'h05: begin alu = 4'h2; br = 1'b1; bne = 1'b1; rsu = 1'b1; rtu = 1'b1; end
         6'h02: jmp = 1'b1;
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         {alu, src, sh, rdst, wr, mr, mw, m2r, br, bne, jmp} = '0;
         rsu = 1'b0; rtu = 1'b0;
      end
      dest = rdst ? instr[15:11] : instr[20:16];
      if (dest == 5'd0) wr = 1'b0;
      e.valid   = 1'b1;
      e.illegal = ~legal;
      e.alu     = alu;
      e.ctl     = {src, sh, rdst, wr, mr, mw, m2r, br, bne, jmp};
      e.rs      = rsd;
      e.rt      = rtd;
      e.imm     = zx ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
      e.pc      = pc;
      e.jt      = {pc[31:28], instr[25:0], 2'b00};
      e.shamt   = instr[10:6];
      e.rta     = instr[20:16];
      e.rda     = instr[15:11];
      return e;
   endfunction

   task automatic compare_out(input string name);
      exp_t e;
      e = sb_q.pop_front();
      check({name, ".valid"},   bus.ex_valid, e.valid);
      check({name, ".illegal"}, bus.ex_illegal, e.illegal);
      check({name, ".alu"},     bus.ex_alu_control, e.alu);
      check({name, ".ctl"},     {bus.ex_alu_source, bus.ex_alu_source_shift, bus.ex_reg_dst,
                                 bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                 bus.ex_mem_to_reg, bus.ex_branch, bus.ex_branch_ne,
                                 bus.ex_jump}, e.ctl);
      check({name, ".rs"},      bus.ex_rs, e.rs);
      check({name, ".rt"},      bus.ex_rt, e.rt);
      check({name, ".imm"},     bus.ex_imm, e.imm);
      check({name, ".pc"},      bus.ex_pc, e.pc);
      check({name, ".jt"},      bus.ex_jump_target, e.jt);
      check({name, ".shamt"},   bus.ex_shamt, e.shamt);
      check({name, ".rt_addr"}, bus.ex_rt_addr, e.rta);
      check({name, ".rd_addr"}, bus.ex_rd_addr, e.rda);
      ex_model = e;
   endtask

   // One decode cycle: drive after the falling edge, check combinational outputs,
   // push the expected ID/EX contents, then compare just after the rising edge.
   task automatic step(input string name, input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic fl, output logic stalled);
      exp_t e;
      logic rsu, rtu, hz, exp_stall;
      @(negedge clk);
      bus.id_valid    = v;
      bus.id_instr    = instr;
      bus.id_pc_plus4 = pc;
      bus.rs_data     = rsd;
      bus.rt_data     = rtd;
      bus.flush       = fl;
      #1;
      e  = ref_decode(instr, pc, rsd, rtd, rsu, rtu);
      hz = v && ex_model.valid && ex_model.ctl[5] && (ex_model.rta != 5'd0) &&
           ((rsu && instr[25:21] == ex_model.rta) || (rtu && instr[20:16] == ex_model.rta));
      exp_stall = hz && !fl;
      check({name, ".stall"},   bus.stall, exp_stall);
      check({name, ".rs_addr"}, bus.rs_addr, instr[25:21]);
      check({name, ".rt_addr"}, bus.rt_addr, instr[20:16]);
      if (fl || hz || !v) e = '0;
      sb_q.push_back(e);
      stalled = exp_stall;
      @(posedge clk);
      #1;
      compare_out(name);
   endtask

   function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] a, b, c;
      a = (($urandom_range(0, 4) == 0) ? 5'd0 : 5'd8) + 5'($urandom_range(0, 3));
      b = 5'd8 + 5'($urandom_range(0, 3));
      c = 5'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
         0: return mk_r(6'h20, a, b, c, 5'd0);
         1: return mk_r(6'h03, 5'd0, b, c, 5'($urandom_range(0, 31)));
         2: return mk_r(6'h06, a, b, c, 5'd0);
         3: return mk_i(6'h08, a, b, 16'($urandom));
         4: return mk_i(6'h0E, a, b, 16'($urandom));
         5: return mk_i(6'h23, a, b, 16'($urandom));
         6: return mk_i(6'h23, a, b, 16'($urandom));
         7: return mk_i(6'h2B, a, b, 16'($urandom));
         8: return mk_i(6'h04, a, b, 16'($urandom));
         default: return {6'h02, 26'($urandom)};
      endcase
   endfunction

   initial begin
      logic        st;
      logic [31:0] instr;
      reset           = 1'b1;
      bus.id_valid    = 1'b0;
      bus.id_instr    = 32'h0;
      bus.id_pc_plus4 = 32'h0;
      bus.rs_data     = 32'h0;
      bus.rt_data     = 32'h0;
      bus.flush       = 1'b0;
      ex_model        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset.valid", bus.ex_valid, 1'b0);
      check("reset.stall", bus.stall, 1'b0);

      step("addi",  1'b1, 32'h2208FFFC, 32'h0040_0004, 32'd10, 32'd77, 1'b0, st);
      step("ori",   1'b1, 32'h3608F000, 32'h0040_0008, 32'h1234, 32'h5, 1'b0, st);
      step("sra",   1'b1, 32'h000A48C3, 32'h0040_000C, 32'h0, 32'hF000_0000, 1'b0, st);
      step("bne",   1'b1, 32'h1509FFFF, 32'h0040_0010, 32'd3, 32'd4, 1'b0, st);
      step("ill",   1'b1, 32'hFC221234, 32'h0040_0014, 32'd1, 32'd2, 1'b0, st);
      step("j",     1'b1, 32'h08100010, 32'hA000_0010, 32'd0, 32'd0, 1'b0, st);
      step("nop",   1'b1, 32'h00000000, 32'h0040_0018, 32'd9, 32'd9, 1'b0, st);

      // load-use: lw $t0 then add $t1,$t0,$t2 stalls once, then loads
      step("lw1",   1'b1, 32'h8E080000, 32'h0040_001C, 32'h100, 32'h0, 1'b0, st);
      step("use1",  1'b1, 32'h010A4820, 32'h0040_0020, 32'd5, 32'd6, 1'b0, st);
      step("use1b", 1'b1, 32'h010A4820, 32'h0040_0020, 32'd5, 32'd6, 1'b0, st);
      // same pair with flush in the hazard cycle
      step("lw2",   1'b1, 32'h8E080000, 32'h0040_0024, 32'h100, 32'h0, 1'b0, st);
      step("use2f", 1'b1, 32'h010A4820, 32'h0040_0028, 32'd5, 32'd6, 1'b1, st);
      step("use2",  1'b1, 32'h010A4820, 32'h0040_0028, 32'd5, 32'd6, 1'b0, st);
      // sw reads rt: a load into its rt stalls
      step("lw3",   1'b1, 32'h8E080000, 32'h0040_002C, 32'h0, 32'h0, 1'b0, st);
      step("sw3",   1'b1, 32'hAE280004, 32'h0040_0030, 32'h8, 32'h9, 1'b0, st);
      step("sw3b",  1'b1, 32'hAE280004, 32'h0040_0030, 32'h8, 32'h9, 1'b0, st);
      // load into $zero never stalls
      step("lw0",   1'b1, 32'h8E000000, 32'h0040_0034, 32'h0, 32'h0, 1'b0, st);
      step("use0",  1'b1, 32'h000A4820, 32'h0040_0038, 32'h1, 32'h2, 1'b0, st);
      step("idle",  1'b0, 32'h2208FFFC, 32'h0040_003C, 32'h1, 32'h2, 1'b0, st);

      // reset mid-stream while a load-use stall is pending
      step("lw4",   1'b1, 32'h8E080000, 32'h0040_0040, 32'h7, 32'h0, 1'b0, st);
      @(negedge clk);
      bus.id_valid = 1'b1;
      bus.id_instr = 32'h010A4820;
      #1;
      check("pre_rst.stall", bus.stall, 1'b1);
      reset = 1'b1;
      #1;
      check("rst.valid", bus.ex_valid, 1'b0);
      check("rst.mem_read", bus.ex_mem_read, 1'b0);
      check("rst.rt_addr", bus.ex_rt_addr, 5'd0);
      check("rst.rs", bus.ex_rs, 32'h0);
      check("rst.stall", bus.stall, 1'b0);
      @(negedge clk);
      reset    = 1'b0;
      ex_model = '0;
      step("post_rst", 1'b1, 32'h010A4820, 32'h0040_0044, 32'd11, 32'd12, 1'b0, st);

      // random stream; a stalled instruction is held and re-decoded like IF/ID would
      st    = 1'b0;
      instr = 32'h0;
      for (int i = 0; i < 80; i++) begin
         if (!st) instr = rand_instr();
         step("rnd", ($urandom_range(0, 7) != 0), instr, 32'($urandom), 32'($urandom),
              32'($urandom), ($urandom_range(0, 9) == 0), st);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Instruction-decode stage and ID/EX pipeline register of the pipelined MIPS core, sitting directly upstream of the execute-stage ALU. It decodes the 32-bit instruction held in IF/ID and produces the ALU's operand and control set: `alu_control`, `alu_source`, `alu_source_shift`, `reg_dst`, extended immediate and branch PC base. It also produces the memory and writeback controls. Load-use hazards are detected here: the stage stalls the front end and inserts bubbles. A flush from branch resolution clears the registered instruction.

## Interface
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all registered outputs
- `id_valid`  in  1  IF/ID holds a real instruction
- `id_instr`  in  32  instruction word
- `id_pc_plus4`  in  32  PC+4 of that instruction
- `rs_data`, `rt_data`  in  32  register-file read data for `rs_addr`/`rt_addr` (combinational read)
- `flush`  in  1  discard the current decode and write a bubble into ID/EX
- `rs_addr`, `rt_addr`  out  5  combinational, `id_instr[25:21]` / `[20:16]`
- `stall`  out  1  combinational; hold PC and IF/ID this cycle
- `ex_valid`, `ex_illegal`  out  1  registered
- `ex_rs`, `ex_rt`, `ex_imm`, `ex_pc`, `ex_jump_target`  out  32  registered
- `ex_shamt`, `ex_rt_addr`, `ex_rd_addr`  out  5  registered
- `ex_alu_control`  out  4  registered
- `ex_alu_source`, `ex_alu_source_shift`, `ex_reg_dst`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch`, `ex_branch_ne`, `ex_jump`  out  1  registered

## Operation
- ALU codes:
  - add 0001, sub 0010, and 0011, or 0100, xor 0101, nor 0110, slt 0111, sll 1000, srl 1001, sra 1010
  - bubble 0000
- R-type (op 0x00), `reg_dst`=1, `reg_write`=1:
  - by funct: add/addu 0x20/0x21→0001; sub/subu 0x22/0x23→0010; and 0x24→0011; or 0x25→0100; xor 0x26→0101; nor 0x27→0110; slt 0x2A→0111.
  - sll/srl/sra 0x00/0x02/0x03 →1000/1001/1010 with `alu_source_shift`=1.
  - sllv/srlv/srav 0x04/0x06/0x07 → same codes with `alu_source_shift`=0.
- I-type, `alu_source`=1, `reg_dst`=0:
  - addi/addiu 0x08/0x09→0001; slti 0x0A→0111; andi 0x0C→0011; ori 0x0D→0100; xori 0x0E→0101. All `reg_write`=1.
  - lw 0x23→0001, with `mem_read`, `mem_to_reg` and `reg_write` set.
  - sw 0x2B→0001, with `mem_write` set.
- Branch: beq 0x04 / bne 0x05 → 0010, `alu_source`=0, `branch`=1; `branch_ne`=1 for bne only.
- Jump: j 0x02 → `jump`=1, ALU code 0000, `jump_target`={pc_plus4[31:28], instr[25:0], 2'b00}.
- Immediate: zero-extend `instr[15:0]` for andi/ori/xori; sign-extend for all other opcodes.
- `ex_pc` ← `id_pc_plus4`.
- `ex_shamt` ← `instr[10:6]`.
- `ex_rs`/`ex_rt` ← `rs_data`/`rt_data`.
- `reg_write` is forced to 0 when the destination register is 0. Instruction 0x00000000 therefore decodes to a harmless sll with no write.
- Unsupported opcode or funct: all controls 0, `ex_valid`=1, `ex_illegal`=1 for that cycle.
- Register usage:
  - `rs` is used by all instructions except sll/srl/sra and j.
  - `rt` is used by R-type, beq, bne and sw.
- Load-use hazard: `hz` = `ex_valid & ex_mem_read & (ex_rt_addr≠0) & ((rs used & rs_addr==ex_rt_addr) | (rt used & rt_addr==ex_rt_addr))`, qualified by `id_valid`.
- `stall` = `hz & ~flush`.
- Next-state priority on each rising edge:
  1. `reset` (asynchronous): all `ex_*` = 0.
  2. `flush`: write a bubble (all `ex_*` = 0).
  3. `hz`: write a bubble. IF/ID is held externally, so the same instruction re-decodes next cycle.
  4. `~id_valid`: write a bubble.
  5. Otherwise: load the decoded values, `ex_valid`=1.

## Timing
- Decode and register in one cycle: `id_instr` present at edge N appears on `ex_*` after edge N.
- `stall`, `rs_addr` and `rt_addr` are combinational within the cycle. `stall` lasts exactly 1 cycle per load-use; the second decode of that instruction sees a bubble in ID/EX.
- `flush` together with `hz` → bubble, `stall`=0.
- Reset mid-stream: outputs clear immediately. The first post-reset edge with `id_valid` loads normally.

## Test plan
- Reset while `ex_*` is nonzero → all outputs 0 before the next edge; `stall`=0.
- addi $t0,$s0,-4 (0x2208FFFC), `rs_data`=10 → next cycle: `ex_alu_control`=0001, `alu_source`=1, `ex_imm`=0xFFFFFFFC, `reg_dst`=0, `reg_write`=1, `ex_rt_addr`=8.
- ori 0x3608F000 → `ex_imm`=0x0000F000, code 0100. sra $t1,$t2,3 (0x000A48C3) → code 1010, `alu_source_shift`=1, `ex_shamt`=3.
- lw $t0,0($s0) followed by add $t1,$t0,$t2 → `stall`=1 for 1 cycle; one bubble (`ex_valid`=0); then add registered with code 0001.
- Same lw/add pair with `flush`=1 in the hazard cycle → `stall`=0, bubble written.
- Opcode 0x3F → `ex_illegal`=1, all controls 0. bne 0x1509FFFF → code 0010, `branch`=1, `branch_ne`=1, `ex_imm`=0xFFFFFFFF.
